// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step sequencer for the MIPS core. Produces a one-cycle clock-enable
// (cpu_ce) either at a fixed divided rate (free-run) or once per debounced
// button press (single-step). It also honours halt requests from the core.
//
// Ports:
//   clk        board clock, rising edge
//   SYS_reset  asynchronous, active-low reset
//   mode_run   1 = free-run, 0 = single-step (synchronous level)
//   step_btn   raw push-button, asynchronous, active-high
//   halt_req   core asks to stop; only looked at while cpu_ce = 1
//   resume     synchronous pulse that leaves HALTED
//   cpu_ce     registered step enable, core commits when high
//   CLK_led    toggles on every cpu_ce pulse
//   state      00 HOLD, 01 RUN, 10 STEP, 11 HALTED
//   step_count number of cpu_ce pulses since reset (wraps)
module cpu_run_ctrl #(
  parameter int unsigned DIVISOR  = 1,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        SYS_reset,
  input  logic        mode_run,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic        resume,
  output logic        cpu_ce,
  output logic        CLK_led,
  output logic [1:0]  state,
  output logic [31:0] step_count
);

  localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t             state_reg, state_next;
  logic               hold_done_reg;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               cpu_ce_reg, cpu_ce_next;
  logic               led_reg;
  logic [31:0]        count_reg;
  logic [1:0]         sync_reg;
  logic [DEB_W-1:0]   deb_cnt_reg;
  logic               acc_reg;
  logic               acc_d_reg;

  logic halt_hit;
  logic tick;
  logic press;

  // Halt is only honoured in a cycle where the core actually commits.
  assign halt_hit = cpu_ce_reg & halt_req;
  assign tick     = (div_reg == DIV_LAST);
  // One-cycle strobe on an accepted 0->1 button transition.
  assign press    = acc_reg & ~acc_d_reg;

  // State register
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_reg <= HOLD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: halt beats mode change, mode change beats tick/step.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HOLD: begin
        if (hold_done_reg) state_next = mode_run ? RUN : STEP;
      end
      RUN: begin
        if (halt_hit)       state_next = HALTED;
        else if (!mode_run) state_next = STEP;
      end
      STEP: begin
        if (halt_hit)      state_next = HALTED;
        else if (mode_run) state_next = RUN;
      end
      HALTED: begin
        if (resume) state_next = mode_run ? RUN : STEP;
      end
      default: state_next = HOLD;
    endcase
  end

  // Output logic: next cpu_ce and divider value. The divider sits at 0
  // outside RUN, so any entry into RUN starts a full DIVISOR period.
  always_comb begin
    cpu_ce_next = 1'b0;
    div_next    = '0;
    case (state_reg)
      RUN: begin
        if (!halt_hit && mode_run) begin
          if (tick) cpu_ce_next = 1'b1;
          else      div_next    = div_reg + DIV_W'(1);
        end
      end
      STEP: begin
        // Presses seen in any other state are simply dropped.
        if (!halt_hit && !mode_run && press) cpu_ce_next = 1'b1;
      end
      default: begin
        cpu_ce_next = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      hold_done_reg <= 1'b0;
      div_reg       <= '0;
      cpu_ce_reg    <= 1'b0;
      led_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      // HOLD is only entered from reset, so this flag marks the second
      // post-reset edge as the one that leaves HOLD.
      hold_done_reg <= 1'b1;
      div_reg       <= div_next;
      cpu_ce_reg    <= cpu_ce_next;
      if (cpu_ce_next) begin
        led_reg   <= ~led_reg;
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // Button synchronizer and debouncer, active in every state so the
  // accepted level never goes stale.
  always_ff @(posedge clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      sync_reg    <= 2'b00;
      deb_cnt_reg <= '0;
      acc_reg     <= 1'b0;
      acc_d_reg   <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], step_btn};
      acc_d_reg <= acc_reg;
      if (sync_reg[1] != acc_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          acc_reg     <= sync_reg[1];
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  assign cpu_ce     = cpu_ce_reg;
  assign CLK_led    = led_reg;
  assign state      = state_reg;
  assign step_count = count_reg;

endmodule
